// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory: parses header/word/checksum
// framing, drives the memory write port and holds the CPU until a verified image is in.
module imem_loader #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] write_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_LO,
      S_HI,
      S_WRITE,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   localparam int         HI_W    = DATA_W - 8;
   localparam int         CNT_W   = ADDR_W + 1;
   localparam logic [8:0] DEPTH_B = 9'(DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   index_q, index_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [7:0]          csum_q, csum_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                in_ready_q, in_ready_d;
   logic                wr_en_q, wr_en_d;
   logic                cpu_hold_q, cpu_hold_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                xfer;
   logic                last_word;

   assign xfer      = in_valid && in_ready_q;
   assign last_word = ({1'b0, index_q} == (count_q - CNT_W'(1)));

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      count_d = count_q;
      csum_d  = csum_q;
      data_d  = data_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_HDR;
               index_d = '0;
               csum_d  = '0;
            end
         end
         S_HDR: begin
            if (xfer) begin
               csum_d  = csum_q ^ in_data;
               count_d = in_data[CNT_W-1:0];
               if (in_data == 8'd0 || {1'b0, in_data} > DEPTH_B) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_LO;
               end
            end
         end
         S_LO: begin
            if (xfer) begin
               csum_d      = csum_q ^ in_data;
               data_d[7:0] = in_data;
               state_d     = S_HI;
            end
         end
         S_HI: begin
            // Upper bits beyond the instruction width must be zero; otherwise nothing is written.
            if (xfer) begin
               if (in_data[7:HI_W] != '0) begin
                  state_d = S_ERR;
               end else begin
                  csum_d             = csum_q ^ in_data;
                  data_d[DATA_W-1:8] = in_data[HI_W-1:0];
                  state_d            = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (last_word) begin
               state_d = S_CHK;
            end else begin
               index_d = index_q + ADDR_W'(1);
               state_d = S_LO;
            end
         end
         S_CHK: begin
            if (xfer) begin
               state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with the state itself.
      in_ready_d = (state_d == S_HDR) || (state_d == S_LO) ||
                   (state_d == S_HI)  || (state_d == S_CHK);
      wr_en_d    = (state_d == S_WRITE);
      done_d     = (state_d == S_DONE);
      error_d    = (state_d == S_ERR);
      cpu_hold_d = (state_d != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         index_q    <= '0;
         count_q    <= '0;
         csum_q     <= '0;
         data_q     <= '0;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         count_q    <= count_d;
         csum_q     <= csum_d;
         data_q     <= data_d;
         in_ready_q <= in_ready_d;
         wr_en_q    <= wr_en_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = index_q;
   assign write_data = data_q;
   assign cpu_hold   = cpu_hold_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule
